// File: rtl/hevc_luma_subpel_block_if.sv
// Row-stream bus of the HEVC luma sub-pel interpolator: padded reference rows in, filtered rows out.
// Valid/ready on both sides: a row moves on a rising edge with valid && ready; the sender holds it stable while valid && !ready.
interface hevc_luma_subpel_block_if #(
    parameter int N = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [(N+7)*8-1:0] in_row;
    logic               out_valid;
    logic               out_ready;
    logic [N*8-1:0]     out_row;
    logic               out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_last
    );
    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_row, out_last
    );
endinterface

// File: rtl/hevc_luma_subpel_block.sv
// Separable HEVC luma quarter-pel interpolator: 8-tap horizontal filter per row, 8-tap vertical
// filter across a line buffer of horizontal results, rounding and clipping to 8 bits.
module hevc_luma_subpel_block #(
    parameter int N     = 8,
    parameter int BLK_H = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [1:0] i_frac_x,
    input  logic [1:0] i_frac_y,
    output logic       o_busy,
    output logic [1:0] o_state,
    hevc_luma_subpel_block_if.slave row_if
);
    localparam int            CW        = $clog2(BLK_H + 7);
    localparam logic [CW-1:0] FILL_LAST = CW'(6);
    localparam logic [CW-1:0] RUN_LAST  = CW'(BLK_H + 6);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_frac_x;
    logic [1:0]         r_frac_y;
    logic [CW-1:0]      r_row_cnt;
    // Seven stored rows; the row being accepted acts as the eighth (newest) tap.
    logic signed [15:0] r_lb [7][N];
    logic [N*8-1:0]     r_out_row;
    logic               r_out_valid;
    logic               r_out_last;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_consume;
    logic signed [15:0] w_h [N];
    logic [N*8-1:0]     w_pix;

    function automatic logic signed [23:0] fir8(input logic [1:0] frac, input logic [7:0][23:0] p);
        logic signed [23:0] s0, s1, s2, s3, s4, s5, s6, s7;
        s0 = signed'(p[0]); s1 = signed'(p[1]); s2 = signed'(p[2]); s3 = signed'(p[3]);
        s4 = signed'(p[4]); s5 = signed'(p[5]); s6 = signed'(p[6]); s7 = signed'(p[7]);
        case (frac)
            2'd0: fir8 = s3 <<< 6;
            2'd1: fir8 = -s0 + (s1 <<< 2) - ((s2 <<< 3) + (s2 <<< 1))
                       + ((s3 <<< 6) - (s3 <<< 2) - (s3 <<< 1)) + ((s4 <<< 4) + s4)
                       - ((s5 <<< 2) + s5) + s6;
            2'd2: fir8 = -s0 + (s1 <<< 2) - ((s2 <<< 3) + (s2 <<< 1) + s2)
                       + ((s3 <<< 5) + (s3 <<< 3)) + ((s4 <<< 5) + (s4 <<< 3))
                       - ((s5 <<< 3) + (s5 <<< 1) + s5) + (s6 <<< 2) - s7;
            default: fir8 = s1 - ((s2 <<< 2) + s2) + ((s3 <<< 4) + s3)
                       + ((s4 <<< 6) - (s4 <<< 2) - (s4 <<< 1))
                       - ((s5 <<< 3) + (s5 <<< 1)) + (s6 <<< 2) - s7;
        endcase
    endfunction

    always_comb begin
        logic [7:0][23:0] hp;
        hp = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) begin
                hp[k] = {16'd0, row_if.in_row[8*(i+k) +: 8]};
            end
            w_h[i] = 16'(fir8(r_frac_x, hp));
        end
    end

    always_comb begin
        logic [7:0][23:0]   vp;
        logic signed [23:0] v;
        logic signed [23:0] sh;
        vp    = '0;
        v     = '0;
        sh    = '0;
        w_pix = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 7; k++) begin
                vp[k] = 24'(r_lb[k][i]);
            end
            vp[7] = 24'(w_h[i]);
            v     = fir8(r_frac_y, vp);
            sh    = (v + 24'sd2048) >>> 12;
            if (sh < 24'sd0)        w_pix[8*i +: 8] = 8'd0;
            else if (sh > 24'sd255) w_pix[8*i +: 8] = 8'd255;
            else                    w_pix[8*i +: 8] = sh[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FILL;
            S_FILL:  if (w_accept && r_row_cnt == FILL_LAST) w_next = S_RUN;
            S_RUN:   if (w_accept && r_row_cnt == RUN_LAST) w_next = S_DRAIN;
            default: if (w_consume) w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        o_busy     = 1'b1;
        case (r_state)
            S_IDLE:  o_busy     = 1'b0;
            S_FILL:  w_in_ready = 1'b1;
            S_RUN:   w_in_ready = !r_out_valid || row_if.out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept  = row_if.in_valid && w_in_ready;
    assign w_consume = r_out_valid && row_if.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frac_x    <= 2'd0;
            r_frac_y    <= 2'd0;
            r_row_cnt   <= '0;
            r_out_row   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int s = 0; s < 7; s++) begin
                for (int i = 0; i < N; i++) r_lb[s][i] <= 16'sd0;
            end
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_frac_x  <= i_frac_x;
                r_frac_y  <= i_frac_y;
                r_row_cnt <= '0;
            end
            if (w_accept) begin
                r_row_cnt <= r_row_cnt + CW'(1);
                for (int i = 0; i < N; i++) begin
                    for (int s = 0; s < 6; s++) r_lb[s][i] <= r_lb[s+1][i];
                    r_lb[6][i] <= w_h[i];
                end
            end
            // A load in RUN wins over a consume at the same edge, so the stream never bubbles.
            if (w_accept && r_state == S_RUN) begin
                r_out_row   <= w_pix;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_row_cnt == RUN_LAST);
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign row_if.in_ready  = w_in_ready;
    assign row_if.out_valid = r_out_valid;
    assign row_if.out_row   = r_out_row;
    assign row_if.out_last  = r_out_last;
    assign o_state          = r_state;
endmodule

// File: tb/tb_hevc_luma_subpel_block.sv
// Scoreboard bench for hevc_luma_subpel_block: a multiply-based golden model queues expected rows
// as input rows are accepted; a negedge monitor pops and compares them as the DUT hands rows out.
`timescale 1ns/1ps
module tb_hevc_luma_subpel_block;
    localparam int N     = 8;
    localparam int BLK_H = 8;
    localparam int RW    = (N + 7) * 8;
    localparam int OW    = N * 8;
    localparam int M_RAND = 0, M_RAMP = 1, M_ROWC = 2, M_CLIPA = 3, M_CLIPB = 4, M_C77 = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] frac_x = 2'd0;
    logic [1:0] frac_y = 2'd0;
    logic       busy;
    logic [1:0] state;

    hevc_luma_subpel_block_if #(.N(N)) bus ();

    hevc_luma_subpel_block #(.N(N), .BLK_H(BLK_H)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_frac_x (frac_x),
        .i_frac_y (frac_y),
        .o_busy   (busy),
        .o_state  (state),
        .row_if   (bus)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_pass   = 0;
    int             taps [4][8];
    int             cur_fx = 0;
    int             cur_fy = 0;
    int             rdy_mode = 0;
    int             rdy_ph = 0;
    logic [OW:0]    exp_q [$];
    logic [RW-1:0]  blk_rows [$];
    logic [OW-1:0]  got_rows [$];
    logic           stall_prev = 1'b0;
    logic [OW:0]    stall_val = '0;

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int hval(input logic [RW-1:0] row, input int fx, input int i);
        int s = 0;
        for (int k = 0; k < 8; k++) s += taps[fx][k] * int'(row[8*(i+k) +: 8]);
        return s;
    endfunction

    function automatic logic [OW-1:0] model_out(input int newest);
        logic [OW-1:0] res = '0;
        for (int i = 0; i < N; i++) begin
            int v = 0;
            int o;
            for (int k = 0; k < 8; k++) v += taps[cur_fy][k] * hval(blk_rows[newest-7+k], cur_fx, i);
            o = (v + 2048) >>> 12;
            if (o < 0) o = 0;
            if (o > 255) o = 255;
            res[8*i +: 8] = 8'(o);
        end
        return res;
    endfunction

    function automatic logic [RW-1:0] gen_row(input int mode, input int r);
        logic [RW-1:0] row = '0;
        int px;
        for (int j = 0; j < N + 7; j++) begin
            case (mode)
                M_RAND:  px = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 255 : 0)
                                                          : int'($urandom_range(0, 255));
                M_RAMP:  px = 10 * j;
                M_ROWC:  px = 10 * r;
                M_CLIPA: px = (j % 8 == 3 || j % 8 == 4) ? 255 : 0;
                M_CLIPB: px = (j % 8 == 3 || j % 8 == 4) ? 0 : 255;
                default: px = 77;
            endcase
            row[8*j +: 8] = 8'(px);
        end
        return row;
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) bus.out_ready = 1'b1;
            else begin
                bus.out_ready = (rdy_ph == 0 || rdy_ph == 3);
                rdy_ph = (rdy_ph + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && bus.out_valid) check("stall_hold", {bus.out_last, bus.out_row}, stall_val);
            if (bus.out_valid && !bus.out_ready) check("in_ready_stall", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [OW:0] e;
                    e = exp_q.pop_front();
                    check("out_row", bus.out_row, e[OW-1:0]);
                    check("out_last", bus.out_last, e[OW]);
                end
                got_rows.push_back(bus.out_row);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_val  = {bus.out_last, bus.out_row};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drive_row(input logic [RW-1:0] row, input int gap);
        logic acc = 1'b0;
        int   t = 0;
        int   a;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", acc, 1);
        end else begin
            blk_rows.push_back(row);
            a = blk_rows.size() - 1;
            if (a >= 7) exp_q.push_back({a == BLK_H + 6, model_out(a)});
            check("out_valid_after_accept", bus.out_valid, a >= 7);
        end
    endtask

    task automatic begin_block(input int fx, input int fy);
        cur_fx = fx;
        cur_fy = fy;
        blk_rows.delete();
        got_rows.delete();
        frac_x = 2'(fx);
        frac_y = 2'(fy);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        frac_x = 2'($urandom_range(0, 3));
        frac_y = 2'($urandom_range(0, 3));
        check("busy_after_start", busy, 1);
        check("in_ready_fill", bus.in_ready, 1);
    endtask

    task automatic run_block(input int fx, input int fy, input int mode, input int gaps);
        int t = 0;
        begin_block(fx, fy);
        for (int r = 0; r < BLK_H + 7; r++) drive_row(gen_row(mode, r), gaps ? $urandom_range(0, 2) : 0);
        while (busy && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("block_done", busy, 0);
        check("exp_q_empty", exp_q.size(), 0);
        check("rows_out", got_rows.size(), BLK_H);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] g;
        taps[0] = '{0, 0, 0, 64, 0, 0, 0, 0};
        taps[1] = '{-1, 4, -10, 58, 17, -5, 1, 0};
        taps[2] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        taps[3] = '{0, 1, -5, 17, 58, -10, 4, -1};
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_row", bus.out_row, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_block(0, 0, M_RAND, 0);
        if (got_rows.size() == BLK_H)
            for (int r = 0; r < BLK_H; r++) begin
                g = got_rows[r];
                for (int i = 0; i < N; i++) check("int_pel", g[8*i +: 8], blk_rows[r+3][8*(i+3) +: 8]);
            end

        run_block(1, 0, M_RAMP, 0);
        if (got_rows.size() == BLK_H) begin
            g = got_rows[BLK_H-1];
            for (int i = 0; i < N; i++) check("ramp_qpel", g[8*i +: 8], 10 * i + 32);
        end

        run_block(0, 2, M_ROWC, 0);
        if (got_rows.size() == BLK_H)
            for (int r = 0; r < BLK_H; r++) begin
                g = got_rows[r];
                check("vert_half", g[7:0], 10 * r + 35);
            end

        run_block(2, 0, M_CLIPA, 0);
        if (got_rows.size() == BLK_H) begin
            g = got_rows[0];
            check("clip_high", g[7:0], 255);
        end
        run_block(2, 0, M_CLIPB, 0);
        if (got_rows.size() == BLK_H) begin
            g = got_rows[0];
            check("clip_low", g[7:0], 0);
        end

        rdy_mode = 1;
        run_block(2, 2, M_RAND, 1);
        run_block(1, 3, M_RAND, 1);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        begin_block(2, 2);
        for (int r = 0; r < 10; r++) drive_row(gen_row(M_RAND, r), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_row", bus.out_row, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;

        run_block(3, 1, M_C77, 0);
        if (got_rows.size() == BLK_H)
            for (int r = 0; r < BLK_H; r++) check("fresh_77", got_rows[r], {N{8'd77}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
